// File: rtl/tree_node_pkg.sv
// Shared types and constants for the tree fan-out node.
package tree_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        BCAST = 2'd2
    } state_e;

    // Destination field width: one bit more than needed to index the children,
    // so every node has an out-of-range region that contains the all-ones code.
    function automatic int unsigned dest_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    // All-ones destination; users slice it down to their dest width.
    localparam logic [31:0] BCAST_DEST  = '1;
    localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/tree_node_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit so level = wptr - rptr.
module tree_node_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wptr;
    logic [LW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign level    = wptr - rptr;
    assign full     = (level == LW'(DEPTH));
    assign empty    = (wptr == rptr);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rptr[AW-1:0]];

    // Pointer update; a push while full is refused even if a pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + LW'(1);
            if (do_pop)  rptr <= rptr + LW'(1);
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tree_fanout_node.sv
// Hierarchy node: buffers an upstream stream and routes each word to one child.
// Optional feature macro: TREE_NODE_BROADCAST_EN (all-ones dest broadcasts).
module tree_fanout_node
    import tree_node_pkg::*;
#(
    parameter  int unsigned NUM_CHILDREN = 5,
    parameter  int unsigned DATA_W       = 32,
    parameter  int unsigned DEPTH        = 4,
    localparam int unsigned DEST_W       = dest_w(NUM_CHILDREN),
    localparam int unsigned LEVEL_W      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic [DEST_W-1:0]       s_dest,
    output logic [NUM_CHILDREN-1:0] m_valid,
    input  logic [NUM_CHILDREN-1:0] m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [LEVEL_W-1:0]      fifo_level,
    output logic [7:0]              err_cnt
);

    localparam int unsigned FW = DATA_W + DEST_W;

`ifdef TREE_NODE_BROADCAST_EN
    localparam logic [DEST_W-1:0] BCAST_IDX = BCAST_DEST[DEST_W-1:0];
`endif

    state_e                  state;
    state_e                  state_next;
    logic [DATA_W-1:0]       out_data;
    logic [DEST_W-1:0]       out_dest;
    logic [NUM_CHILDREN-1:0] sel_mask;
    logic [FW-1:0]           head;
    logic [DATA_W-1:0]       head_data;
    logic [DEST_W-1:0]       head_dest;
    logic                    head_ok;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    load;
    logic                    drop;
    logic                    slot_free;
`ifdef TREE_NODE_BROADCAST_EN
    logic [NUM_CHILDREN-1:0] pending;
    logic                    head_bc;
`endif

    tree_node_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .push_data ({s_data, s_dest}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign s_ready   = ~fifo_full;
    assign head_data = head[FW-1:DEST_W];
    assign head_dest = head[DEST_W-1:0];
    assign head_ok   = (32'(head_dest) < NUM_CHILDREN);
    assign m_data    = out_data;
`ifdef TREE_NODE_BROADCAST_EN
    assign head_bc   = (head_dest == BCAST_IDX);
`endif

    // One-hot select of the child addressed by the word in the output register.
    always_comb begin
        sel_mask = '0;
        for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
            sel_mask[i] = (32'(out_dest) == i);
        end
    end

    // Next-state and outputs: the output slot frees on handshake, and a free slot
    // reloads straight from the FIFO head so back-to-back words keep 1 word/cycle.
    always_comb begin
        state_next = state;
        m_valid    = '0;
        slot_free  = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: slot_free = 1'b1;
            SEND: begin
                m_valid   = sel_mask;
                slot_free = |(m_ready & sel_mask);
            end
`ifdef TREE_NODE_BROADCAST_EN
            BCAST: begin
                m_valid   = pending;
                slot_free = ((pending & ~m_ready) == '0);
            end
`endif
            default: slot_free = 1'b1;
        endcase
        if (slot_free) begin
            state_next = IDLE;
            if (!fifo_empty) begin
                pop = 1'b1;
                if (head_ok) begin
                    load       = 1'b1;
                    state_next = SEND;
`ifdef TREE_NODE_BROADCAST_EN
                end else if (head_bc) begin
                    load       = 1'b1;
                    state_next = BCAST;
`endif
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // State, output register and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_data <= '0;
            out_dest <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                out_data <= head_data;
                out_dest <= head_dest;
            end
            if (drop && (err_cnt != ERR_CNT_MAX)) err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef TREE_NODE_BROADCAST_EN
    // Broadcast pending mask: set on load, each child's bit clears on its ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (load) begin
            pending <= '1;
        end else if (state == BCAST) begin
            pending <= pending & ~m_ready;
        end
    end
`endif

endmodule

// File: tb/tb_tree_fanout_node.sv
// Directed self-checking bench for tree_fanout_node (NUM_CHILDREN=5, DEPTH=4).
module tb_tree_fanout_node;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [3:0]  s_dest = '0;
    logic [4:0]  m_valid;
    logic [4:0]  m_ready = '0;
    logic [31:0] m_data;
    logic [2:0]  fifo_level;
    logic [7:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    tree_fanout_node #(
        .NUM_CHILDREN (5),
        .DATA_W       (32),
        .DEPTH        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_dest     (s_dest),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fifo_level (fifo_level),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] oh(input int d);
        logic [4:0] one;
        one = 5'b00001;
        return one << d;
    endfunction

    // Push n words to an out-of-range child, pacing on s_ready, then drain.
    task automatic push_drops(input int n, output logic [4:0] seen);
        int sent;
        sent = 0;
        seen = '0;
        for (int c = 0; c < n * 3 && sent < n; c++) begin
            seen |= m_valid;
            s_valid = 1'b1;
            s_data  = 32'hDEAD_0000 + 32'(c);
            s_dest  = 4'd6;
            if (s_ready) sent++;
            tick();
        end
        s_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen |= m_valid;
            tick();
        end
        check("drop_sent", 64'(sent), 64'(n));
    endtask

    logic [31:0] words [5];
    logic [4:0]  seen;
    int          exp_err;
    logic [31:0] q_data[$];
    logic [3:0]  q_dest[$];
    int          pushed;
    int          delivered;
    int          first_cyc;
    int          last_cyc;
    int          stall;

    initial begin
        exp_err = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_m_valid", 64'(m_valid), 64'h0);
        check("rst_m_data", 64'(m_data), 64'h0);
        check("rst_err_cnt", 64'(err_cnt), 64'h0);
        check("rst_level", 64'(fifo_level), 64'h0);
        check("rst_s_ready", 64'(s_ready), 64'h1);

        // 1: single route, valid appears on the second edge for one cycle
        m_ready = 5'b11111;
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        s_dest  = 4'd3;
        tick();
        s_valid = 1'b0;
        check("t1_edge1_valid", 64'(m_valid), 64'h0);
        check("t1_edge1_level", 64'(fifo_level), 64'h1);
        tick();
        check("t1_valid", 64'(m_valid), 64'(5'b01000));
        check("t1_data", 64'(m_data), 64'hA5A5_0001);
        tick();
        check("t1_one_cycle", 64'(m_valid), 64'h0);

        // 2: backpressure, 1 word in output register + 4 buffered
        m_ready = '0;
        for (int i = 0; i < 5; i++) begin
            words[i] = 32'hB000_0000 + 32'(i * 17);
            s_valid  = 1'b1;
            s_data   = words[i];
            s_dest   = 4'(i);
            tick();
        end
        s_valid = 1'b0;
        check("t2_full_ready", 64'(s_ready), 64'h0);
        check("t2_full_level", 64'(fifo_level), 64'h4);
        check("t2_head_valid", 64'(m_valid), 64'(5'b00001));
        s_valid = 1'b1;
        s_data  = 32'hBAD0_BAD0;
        s_dest  = 4'd2;
        tick();
        s_valid = 1'b0;
        check("t2_refused_level", 64'(fifo_level), 64'h4);
        m_ready = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_valid%0d", i), 64'(m_valid), 64'(oh(i)));
            check($sformatf("t2_data%0d", i), 64'(m_data), 64'(words[i]));
            tick();
        end
        check("t2_drained_valid", 64'(m_valid), 64'h0);
        check("t2_drained_level", 64'(fifo_level), 64'h0);

        // 4: broadcast (or an all-ones drop when the feature is absent)
`ifdef TREE_NODE_BROADCAST_EN
        m_ready = '0;
        s_valid = 1'b1;
        s_data  = 32'hCAFE_F00D;
        s_dest  = 4'hF;
        tick();
        s_valid = 1'b0;
        tick();
        check("t4_all", 64'(m_valid), 64'(5'b11111));
        m_ready = 5'b00101;
        tick();
        check("t4_after_c1", 64'(m_valid), 64'(5'b11010));
        m_ready = '0;
        tick();
        check("t4_hold", 64'(m_valid), 64'(5'b11010));
        check("t4_data", 64'(m_data), 64'hCAFE_F00D);
        m_ready = 5'b11010;
        tick();
        check("t4_done", 64'(m_valid), 64'h0);
        check("t4_err", 64'(err_cnt), 64'(exp_err));
`else
        m_ready = 5'b11111;
        s_valid = 1'b1;
        s_data  = 32'hCAFE_F00D;
        s_dest  = 4'hF;
        tick();
        s_valid = 1'b0;
        seen = '0;
        for (int c = 0; c < 4; c++) begin
            seen |= m_valid;
            tick();
        end
        exp_err = exp_err + 1;
        check("t4_no_valid", 64'(seen), 64'h0);
        check("t4_err", 64'(err_cnt), 64'(exp_err));
`endif

        // 3: out-of-range dest, counter saturates
        m_ready = 5'b11111;
        push_drops(10, seen);
        exp_err = exp_err + 10;
        check("t3_err10", 64'(err_cnt), 64'(exp_err));
        check("t3_no_valid_a", 64'(seen), 64'h0);
        push_drops(290, seen);
        check("t3_err_sat", 64'(err_cnt), 64'd255);
        check("t3_no_valid_b", 64'(seen), 64'h0);

        // 5: reset mid-transfer with 3 words queued
        m_ready = '0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hD000_0000 + 32'(i);
            s_dest  = 4'(i + 1);
            tick();
        end
        s_valid = 1'b0;
        check("t5_pre_valid", 64'(m_valid), 64'(5'b00010));
        check("t5_pre_level", 64'(fifo_level), 64'h3);
        rst = 1'b1;
        #1;
        check("t5_async_valid", 64'(m_valid), 64'h0);
        check("t5_async_level", 64'(fifo_level), 64'h0);
        check("t5_async_err", 64'(err_cnt), 64'h0);
        tick();
        rst = 1'b0;
        check("t5_rel_ready", 64'(s_ready), 64'h1);
        m_ready = 5'b11111;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            seen |= m_valid;
            tick();
        end
        check("t5_no_replay", 64'(seen), 64'h0);

        // 6: streaming, alternating dest 0/4
        pushed    = 0;
        delivered = 0;
        first_cyc = -1;
        last_cyc  = -1;
        stall     = 0;
        m_ready   = 5'b11111;
        for (int cyc = 0; cyc < 400 && delivered < 100; cyc++) begin
            if (m_valid != '0) begin
                if (q_data.size() == 0) begin
                    check("t6_extra", 64'(m_valid), 64'h0);
                end else begin
                    check("t6_valid", 64'(m_valid), 64'(oh(int'(q_dest[0]))));
                    check("t6_data", 64'(m_data), 64'(q_data[0]));
                    void'(q_data.pop_front());
                    void'(q_dest.pop_front());
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                delivered++;
            end
            if (pushed < 100) begin
                s_valid = 1'b1;
                s_data  = 32'h5000_0000 + 32'(pushed);
                s_dest  = pushed[0] ? 4'd4 : 4'd0;
                if (s_ready) begin
                    q_data.push_back(s_data);
                    q_dest.push_back(s_dest);
                    pushed++;
                end else begin
                    stall++;
                end
            end else begin
                s_valid = 1'b0;
            end
            tick();
        end
        s_valid = 1'b0;
        check("t6_delivered", 64'(delivered), 64'd100);
        check("t6_rate", 64'(last_cyc - first_cyc), 64'd99);
        check("t6_no_stall", 64'(stall), 64'h0);
        check("t6_end_valid", 64'(m_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
